systolic_os_array: RTL and testbench
====================================

# systolic_os_array

Parametrised output-stationary systolic PE array, the next generation of the fixed 8x8 array. It accepts one unskewed activation vector (one element per row) and one weight vector (one element per column) per beat, applies the diagonal skew internally, and accumulates signed products in place. When the job ends it flushes the pipeline and drains the accumulator matrix one row per valid/ready handshake. It sits between the operand feeders and the result writeback path.

## Interface
- ROWS, 4, PE rows; activation lanes; ≥1
- COLS, 4, PE columns; weight lanes; ≥1
- DW, 8, operand width, signed two's complement
- AW, 32, accumulator width, signed; AW ≥ 2·DW
- clk  in  1  clock; all state on rising edge
- rstn  in  1  reset, asynchronous, active-low
- in_valid  in  1  operand beat valid
- in_ready  out  1  array accepts a beat this cycle
- in_last  in  1  qualifies final beat of a job (sampled only with in_valid && in_ready)
- in_a  in  ROWS·DW  activation vector; lane r = bits [r·DW +: DW]
- in_w  in  COLS·DW  weight vector; lane c = bits [c·DW +: DW]
- out_valid  out  1  out_data holds a result row
- out_ready  in  1  downstream accepts the row
- out_data  out  COLS·AW  accumulators of row out_row; lane c = PE(out_row, c)
- out_row  out  max(1,$clog2(ROWS))  row index of out_data
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, COMPUTE, FLUSH, DRAIN.
- IDLE: in_ready=1. An accepted beat moves to COMPUTE (or directly to FLUSH if in_last).
- COMPUTE: in_ready=1. Each accepted beat enters the skew. An accepted beat with in_last moves to FLUSH. Cycles without in_valid insert bubbles; bubbles never accumulate.
- FLUSH: in_ready=0. Counter runs ROWS+COLS-2 cycles, then DRAIN. If ROWS+COLS-2 = 0, the FSM goes straight to DRAIN on the next cycle.
- DRAIN: in_ready=0, out_valid=1, out_row starts at 0. Each out_valid&&out_ready advances out_row. The handshake on row ROWS-1 zeroes all accumulators and the skew, then returns to IDLE.
- Dataflow: activation lane r is delayed r cycles and then shifts right one PE per cycle. Weight lane c is delayed c cycles and then shifts down one PE per cycle. A per-operand valid bit travels with each operand.
- PE(r,c): acc += sext(a)·sext(w) when both arriving operands are valid.
- Arithmetic: full 2·DW signed product, sign-extended to AW. Default accumulation wraps modulo 2^AW.

## Timing
- Reset (async): FSM=IDLE, all accumulators, skew, and valid bits 0. Outputs: in_ready=0 while rstn=0, then 1 in IDLE; out_valid=0, out_data=0, out_row=0, busy=0.
- A beat accepted in cycle t is accumulated into PE(r,c) at the edge ending cycle t+r+c.
- If the last beat is accepted in cycle t, the first out_valid is cycle t+ROWS+COLS-1. With out_ready held high, the last row is accepted in cycle t+ROWS+COLS+ROWS-2.
- In-to-out latency: combinational out_data/out_row are driven from registers only. No path exists from in_* to out_*.
- Backpressure: while out_valid && !out_ready, out_data and out_row hold stable.
- Asserting rstn low mid-job (any state) discards the job. The next job after reset is unaffected.
- in_valid while in_ready=0 is ignored. in_last without an accepted beat is ignored.

## Configuration
- PE_ARR_SAT_EN defined: each accumulate saturates to [-2^(AW-1), 2^(AW-1)-1]. Saturation is sticky per step: the saturated value is kept and later steps may move it back in range.
- PE_ARR_SAT_EN undefined: two's-complement wrap-around.

## Test plan
- Defaults, one beat of a=all 1 and w=all 1 with last, at cycle t: out_valid rises at t+7, 4 rows, every lane = 1; busy falls after row 3; a second identical job also gives 1.
- Three beats with in_a lanes = 1,2,3 and w=all 2, with an idle bubble between beats 1 and 2: every lane = 12; the bubble changes nothing.
- Signed: a=-128, w=-128 gives 16384 everywhere. Mixed lanes a_r=r-1, w_c=5 give out row r lanes = 5·(r-1).
- Backpressure: out_ready low for 5 cycles on row 1: out_data/out_row stable, in_ready=0, no row skipped or repeated.
- Overflow, with AW=16, DW=8 and three beats of 127·127: wrap build = -17149; PE_ARR_SAT_EN build = 32767.
- rstn pulsed low mid-COMPUTE and again mid-DRAIN: outputs return to reset values immediately; a following single-beat job a=3, w=4 yields 12 everywhere.
- Corner shape ROWS=1, COLS=1: out_valid appears one cycle after the last beat; ROWS=2, COLS=5 matches a reference matrix product.

Source files
------------

// File: rtl/systolic_os_array.sv
// Output-stationary ROWS x COLS systolic array: internal diagonal skew, in-place signed MAC, row-wise drain.
// Build macro PE_ARR_SAT_EN selects saturating accumulation; when it is undefined, accumulators wrap.
module systolic_os_array #(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int DW   = 8,
  parameter int AW   = 32,
  localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_last,
  input  logic [ROWS*DW-1:0]   in_a,
  input  logic [COLS*DW-1:0]   in_w,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [COLS*AW-1:0]   out_data,
  output logic [RW-1:0]        out_row,
  output logic                 busy
);

  localparam int FLUSH_N = ROWS + COLS - 2;
  localparam int CW      = $clog2(ROWS + COLS);

  typedef enum logic [1:0] {IDLE, COMPUTE, FLUSH, DRAIN} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] flush_cnt, flush_cnt_nxt;
  logic [RW-1:0] row_nxt;
  logic          fire;
  logic          out_fire;
  logic          drain_done;

  assign fire       = in_valid && in_ready;
  assign out_fire   = out_valid && out_ready;
  assign drain_done = out_fire && (out_row == RW'(ROWS - 1));

  assign in_ready  = rstn && ((state == IDLE) || (state == COMPUTE));
  assign out_valid = (state == DRAIN);
  assign busy      = (state != IDLE);

  always_comb begin
    // NOTE: every output gets a default first, so no path can infer a latch.
    state_nxt     = state;
    flush_cnt_nxt = flush_cnt;
    row_nxt       = out_row;
    case (state)
      IDLE, COMPUTE: begin
        if (fire) begin
          flush_cnt_nxt = '0;
          if (in_last) state_nxt = (FLUSH_N == 0) ? DRAIN : FLUSH;
          else         state_nxt = COMPUTE;
        end
      end
      FLUSH: begin
        if (flush_cnt == CW'(FLUSH_N - 1)) state_nxt = DRAIN;
        else                               flush_cnt_nxt = flush_cnt + CW'(1);
      end
      DRAIN: begin
        if (drain_done) begin
          state_nxt = IDLE;
          row_nxt   = '0;
        end else if (out_fire) begin
          row_nxt = out_row + RW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: registered state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      flush_cnt <= '0;
      out_row   <= '0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_cnt_nxt;
      out_row   <= row_nxt;
    end
  end

  // Skew outputs: operands entering column 0 (activations) and row 0 (weights).
  logic                 a_sk_v [ROWS];
  logic signed [DW-1:0] a_sk_d [ROWS];
  logic                 w_sk_v [COLS];
  logic signed [DW-1:0] w_sk_d [COLS];

  for (genvar r = 0; r < ROWS; r++) begin : g_askew
    if (r == 0) begin : g_lane
      assign a_sk_v[r] = fire;
      assign a_sk_d[r] = in_a[r*DW +: DW];
    end else begin : g_lane
      logic                 v_sr [r];
      logic signed [DW-1:0] d_sr [r];
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          for (int k = 0; k < r; k++) begin
            v_sr[k] <= 1'b0;
            d_sr[k] <= '0;
          end
        end else if (drain_done) begin
          for (int k = 0; k < r; k++) begin
            v_sr[k] <= 1'b0;
            d_sr[k] <= '0;
          end
        end else begin
          v_sr[0] <= fire;
          d_sr[0] <= in_a[r*DW +: DW];
          for (int k = 1; k < r; k++) begin
            v_sr[k] <= v_sr[k-1];
            d_sr[k] <= d_sr[k-1];
          end
        end
      end
      assign a_sk_v[r] = v_sr[r-1];
      assign a_sk_d[r] = d_sr[r-1];
    end
  end

  for (genvar c = 0; c < COLS; c++) begin : g_wskew
    if (c == 0) begin : g_lane
      assign w_sk_v[c] = fire;
      assign w_sk_d[c] = in_w[c*DW +: DW];
    end else begin : g_lane
      logic                 v_sr [c];
      logic signed [DW-1:0] d_sr [c];
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          for (int k = 0; k < c; k++) begin
            v_sr[k] <= 1'b0;
            d_sr[k] <= '0;
          end
        end else if (drain_done) begin
          for (int k = 0; k < c; k++) begin
            v_sr[k] <= 1'b0;
            d_sr[k] <= '0;
          end
        end else begin
          v_sr[0] <= fire;
          d_sr[0] <= in_w[c*DW +: DW];
          for (int k = 1; k < c; k++) begin
            v_sr[k] <= v_sr[k-1];
            d_sr[k] <= d_sr[k-1];
          end
        end
      end
      assign w_sk_v[c] = v_sr[c-1];
      assign w_sk_d[c] = d_sr[c-1];
    end
  end

  // Operands each PE forwards to its right (activation) and lower (weight) neighbour.
  logic                 a_pass_v [ROWS][COLS];
  logic signed [DW-1:0] a_pass_d [ROWS][COLS];
  logic                 w_pass_v [ROWS][COLS];
  logic signed [DW-1:0] w_pass_d [ROWS][COLS];
  logic signed [AW-1:0] acc      [ROWS][COLS];

`ifdef PE_ARR_SAT_EN
  localparam logic signed [AW-1:0] ACC_MAX = {1'b0, {(AW-1){1'b1}}};
  localparam logic signed [AW-1:0] ACC_MIN = {1'b1, {(AW-1){1'b0}}};
`endif

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      logic                   a_v, w_v;
      logic signed [DW-1:0]   a_d, w_d;
      logic signed [2*DW-1:0] prod;
      logic signed [AW-1:0]   acc_nxt;

      if (c == 0) begin : g_a_src
        assign a_v = a_sk_v[r];
        assign a_d = a_sk_d[r];
      end else begin : g_a_src
        assign a_v = a_pass_v[r][c-1];
        assign a_d = a_pass_d[r][c-1];
      end

      if (r == 0) begin : g_w_src
        assign w_v = w_sk_v[c];
        assign w_d = w_sk_d[c];
      end else begin : g_w_src
        assign w_v = w_pass_v[r-1][c];
        assign w_d = w_pass_d[r-1][c];
      end

      assign prod = a_d * w_d;

`ifdef PE_ARR_SAT_EN
      logic signed [AW:0] sum;
      assign sum     = (AW+1)'(acc[r][c]) + (AW+1)'(prod);
      // The extra top bit disagreeing with the sign bit means the AW-bit result overflowed.
      assign acc_nxt = (sum[AW] != sum[AW-1]) ? (sum[AW] ? ACC_MIN : ACC_MAX) : sum[AW-1:0];
`else
      assign acc_nxt = acc[r][c] + AW'(prod);
`endif

      // NOTE: the accumulator array is reset explicitly; an aborted job must not leak into the next one.
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          a_pass_v[r][c] <= 1'b0;
          a_pass_d[r][c] <= '0;
          w_pass_v[r][c] <= 1'b0;
          w_pass_d[r][c] <= '0;
          acc[r][c]      <= '0;
        end else if (drain_done) begin
          a_pass_v[r][c] <= 1'b0;
          a_pass_d[r][c] <= '0;
          w_pass_v[r][c] <= 1'b0;
          w_pass_d[r][c] <= '0;
          acc[r][c]      <= '0;
        end else begin
          a_pass_v[r][c] <= a_v;
          a_pass_d[r][c] <= a_d;
          w_pass_v[r][c] <= w_v;
          w_pass_d[r][c] <= w_d;
          if (a_v && w_v) acc[r][c] <= acc_nxt;
        end
      end
    end
  end

  always_comb begin
    out_data = '0;
    if (out_valid) begin
      for (int c = 0; c < COLS; c++) out_data[c*AW +: AW] = acc[out_row][c];
    end
  end

endmodule

// File: tb/tb_systolic_os_array.sv
// Directed scoreboard bench for systolic_os_array: a 4x4 main instance plus 2x5 (AW=16) and 1x1 corner shapes.
module tb_systolic_os_array;

  localparam int ROWS = 4, COLS = 4, DW = 8, AW = 32, RW = 2;
  localparam int R2 = 2, C2 = 5, AW2 = 16;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic               in_valid, in_ready, in_last, out_valid, out_ready, busy;
  logic [ROWS*DW-1:0] in_a;
  logic [COLS*DW-1:0] in_w;
  logic [COLS*AW-1:0] out_data;
  logic [RW-1:0]      out_row;

  logic               in_valid2, in_ready2, in_last2, out_valid2, out_ready2, busy2;
  logic [R2*DW-1:0]   in_a2;
  logic [C2*DW-1:0]   in_w2;
  logic [C2*AW2-1:0]  out_data2;
  logic [0:0]         out_row2;

  logic               in_valid3, in_ready3, in_last3, out_valid3, out_ready3, busy3;
  logic [DW-1:0]      in_a3, in_w3;
  logic [AW-1:0]      out_data3;
  logic [0:0]         out_row3;

  systolic_os_array #(.ROWS(ROWS), .COLS(COLS), .DW(DW), .AW(AW)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .in_a(in_a), .in_w(in_w), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_row(out_row), .busy(busy)
  );

  systolic_os_array #(.ROWS(R2), .COLS(C2), .DW(DW), .AW(AW2)) dut2 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid2), .in_ready(in_ready2), .in_last(in_last2),
    .in_a(in_a2), .in_w(in_w2), .out_valid(out_valid2), .out_ready(out_ready2),
    .out_data(out_data2), .out_row(out_row2), .busy(busy2)
  );

  systolic_os_array #(.ROWS(1), .COLS(1), .DW(DW), .AW(AW)) dut3 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid3), .in_ready(in_ready3), .in_last(in_last3),
    .in_a(in_a3), .in_w(in_w3), .out_valid(out_valid3), .out_ready(out_ready3),
    .out_data(out_data3), .out_row(out_row3), .busy(busy3)
  );

  typedef struct { int row; logic [COLS*AW-1:0] data; } exp_t;
  typedef struct { int row; logic [C2*AW2-1:0] data; } exp2_t;

  exp_t                  sb[$];
  exp2_t                 sb2[$];
  logic signed [AW-1:0]  model  [ROWS][COLS];
  logic signed [AW2-1:0] model2 [R2][C2];
  int                    va  [ROWS];
  int                    vw  [COLS];
  int                    va2 [R2];
  int                    vw2 [C2];
  int                    checks;
  int                    failures;
  int                    n;
  exp_t                  e0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic signed [AW2-1:0] add16(input logic signed [AW2-1:0] a, input int p);
    int s;
    s = int'(a) + p;
`ifdef PE_ARR_SAT_EN
    if (s > 32767) s = 32767;
    else if (s < -32768) s = -32768;
`endif
    return AW2'(s);
  endfunction

  task automatic clear_models();
    for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) model[r][c] = '0;
    for (int r = 0; r < R2; r++) for (int c = 0; c < C2; c++) model2[r][c] = '0;
    sb.delete();
    sb2.delete();
  endtask

  task automatic set_vec(input int a, input int w);
    for (int r = 0; r < ROWS; r++) va[r] = a;
    for (int c = 0; c < COLS; c++) vw[c] = w;
  endtask

  task automatic beat(input bit last);
    exp_t e;
    for (int r = 0; r < ROWS; r++) in_a[r*DW +: DW] = va[r][DW-1:0];
    for (int c = 0; c < COLS; c++) in_w[c*DW +: DW] = vw[c][DW-1:0];
    in_valid = 1'b1;
    in_last  = last;
    check("in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) model[r][c] = model[r][c] + AW'(va[r] * vw[c]);
    if (last) begin
      for (int r = 0; r < ROWS; r++) begin
        e.row = r;
        for (int c = 0; c < COLS; c++) begin
          e.data[c*AW +: AW] = model[r][c];
          model[r][c] = '0;
        end
        sb.push_back(e);
      end
    end
  endtask

  task automatic drain(input int stall_row, input int stall_cyc);
    int k;
    exp_t e;
    logic [COLS*AW-1:0] hold_d;
    logic [RW-1:0] hold_r;
    k = 1;
    while (!out_valid && k < 64) begin @(posedge clk); #1; k++; end
    check("latency", k, ROWS + COLS - 1);
    for (int i = 0; i < ROWS; i++) begin
      check("out_valid", out_valid, 1'b1);
      if (i == stall_row) begin
        out_ready = 1'b0;
        hold_d = out_data;
        hold_r = out_row;
        in_valid = 1'b1;
        in_last  = 1'b1;
        in_a     = '1;
        in_w     = '1;
        for (int s = 0; s < stall_cyc; s++) begin
          @(posedge clk); #1;
          check("stall_data", out_data, hold_d);
          check("stall_row", out_row, hold_r);
          check("stall_in_ready", in_ready, 1'b0);
          check("stall_valid", out_valid, 1'b1);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
      end
      out_ready = 1'b1;
      check("sb_nonempty", sb.size() > 0, 1'b1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("row", out_row, e.row);
        check("data", out_data, e.data);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    check("busy_after", busy, 1'b0);
    check("valid_after", out_valid, 1'b0);
  endtask

  task automatic beat2(input bit last);
    exp2_t e;
    for (int r = 0; r < R2; r++) in_a2[r*DW +: DW] = va2[r][DW-1:0];
    for (int c = 0; c < C2; c++) in_w2[c*DW +: DW] = vw2[c][DW-1:0];
    in_valid2 = 1'b1;
    in_last2  = last;
    check("in_ready2", in_ready2, 1'b1);
    @(posedge clk); #1;
    in_valid2 = 1'b0;
    in_last2  = 1'b0;
    for (int r = 0; r < R2; r++)
      for (int c = 0; c < C2; c++) model2[r][c] = add16(model2[r][c], va2[r] * vw2[c]);
    if (last) begin
      for (int r = 0; r < R2; r++) begin
        e.row = r;
        for (int c = 0; c < C2; c++) begin
          e.data[c*AW2 +: AW2] = model2[r][c];
          model2[r][c] = '0;
        end
        sb2.push_back(e);
      end
    end
  endtask

  task automatic drain2();
    int k;
    exp2_t e;
    k = 1;
    while (!out_valid2 && k < 64) begin @(posedge clk); #1; k++; end
    check("latency2", k, R2 + C2 - 1);
    out_ready2 = 1'b1;
    for (int i = 0; i < R2; i++) begin
      check("out_valid2", out_valid2, 1'b1);
      check("sb2_nonempty", sb2.size() > 0, 1'b1);
      if (sb2.size() > 0) begin
        e = sb2.pop_front();
        check("row2", out_row2, e.row);
        check("data2", out_data2, e.data);
      end
      @(posedge clk); #1;
    end
    out_ready2 = 1'b0;
    check("busy2_after", busy2, 1'b0);
  endtask

  task automatic pulse_reset(input string tag);
    rstn      = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    #1;
    check({tag, "_in_ready"}, in_ready, 1'b0);
    check({tag, "_out_valid"}, out_valid, 1'b0);
    check({tag, "_out_data"}, out_data, '0);
    check({tag, "_out_row"}, out_row, '0);
    check({tag, "_busy"}, busy, 1'b0);
    #2 rstn = 1'b1;
    clear_models();
    @(posedge clk); #1;
    check({tag, "_ready_after"}, in_ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    failures = 0;
    rstn = 1'b0;
    in_valid  = 1'b0; in_last  = 1'b0; in_a  = '0; in_w  = '0; out_ready  = 1'b0;
    in_valid2 = 1'b0; in_last2 = 1'b0; in_a2 = '0; in_w2 = '0; out_ready2 = 1'b0;
    in_valid3 = 1'b0; in_last3 = 1'b0; in_a3 = '0; in_w3 = '0; out_ready3 = 1'b0;
    clear_models();
    @(posedge clk); #1;
    pulse_reset("reset");

    // Single beat of ones, twice back to back.
    set_vec(1, 1);
    beat(1'b1);
    drain(-1, 0);
    set_vec(1, 1);
    beat(1'b1);
    drain(-1, 0);

    // Three beats with a bubble, drained with backpressure on row 1.
    set_vec(1, 2);
    beat(1'b0);
    @(posedge clk); #1;
    check("bubble_busy", busy, 1'b1);
    set_vec(2, 2);
    beat(1'b0);
    set_vec(3, 2);
    beat(1'b1);
    drain(1, 5);

    // Signed extremes and mixed-sign lanes.
    set_vec(-128, -128);
    beat(1'b1);
    drain(-1, 0);
    for (int r = 0; r < ROWS; r++) va[r] = r - 1;
    for (int c = 0; c < COLS; c++) vw[c] = 5;
    beat(1'b1);
    drain(-1, 0);

    // Reset mid-COMPUTE.
    set_vec(5, 6);
    beat(1'b0);
    beat(1'b0);
    check("compute_busy", busy, 1'b1);
    pulse_reset("rst_compute");

    // Reset mid-DRAIN after the first row is accepted.
    set_vec(9, 9);
    beat(1'b1);
    n = 1;
    while (!out_valid && n < 64) begin @(posedge clk); #1; n++; end
    check("mid_drain_latency", n, ROWS + COLS - 1);
    out_ready = 1'b1;
    e0 = sb.pop_front();
    check("mid_drain_row0", out_row, 0);
    check("mid_drain_data0", out_data, e0.data);
    @(posedge clk); #1;
    check("mid_drain_row1", out_row, 1);
    pulse_reset("rst_drain");

    set_vec(3, 4);
    beat(1'b1);
    drain(-1, 0);

    // 2x5 shape against the reference product, then the 16-bit overflow case.
    for (int k = 0; k < 3; k++) begin
      for (int r = 0; r < R2; r++) va2[r] = int'($urandom_range(20)) - 10;
      for (int c = 0; c < C2; c++) vw2[c] = int'($urandom_range(20)) - 10;
      beat2(k == 2);
    end
    drain2();
    for (int r = 0; r < R2; r++) va2[r] = 127;
    for (int c = 0; c < C2; c++) vw2[c] = 127;
    beat2(1'b0);
    beat2(1'b0);
    beat2(1'b1);
    drain2();

    // 1x1 shape: result visible the cycle after the last beat.
    in_a3 = 8'sd7;
    in_w3 = -8'sd3;
    in_valid3 = 1'b1;
    in_last3  = 1'b1;
    check("in_ready3", in_ready3, 1'b1);
    @(posedge clk); #1;
    in_valid3 = 1'b0;
    in_last3  = 1'b0;
    check("out_valid3", out_valid3, 1'b1);
    check("data3", out_data3, 32'hFFFF_FFEB);
    check("row3", out_row3, 1'b0);
    check("busy3", busy3, 1'b1);
    out_ready3 = 1'b1;
    @(posedge clk); #1;
    out_ready3 = 1'b0;
    check("valid3_after", out_valid3, 1'b0);
    check("busy3_after", busy3, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
